// File: rtl/rs_generic.sv
// rs_generic: parametrised reservation station feeding one functional unit.
// Holds up to DEPTH instructions, snoops NUM_CDB result buses for operand
// wakeup and issues one ready entry per cycle over a valid/ready handshake.
// Optional build macro RS_AGE_ORDER_EN: adds per-entry age counters so the
// oldest ready entry issues first (default build: lowest-index ready entry).
module rs_generic #(
  parameter int DEPTH   = 4,
  parameter int NUM_CDB = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [OP_W-1:0]             alloc_op,
  input  logic [TAG_W-1:0]            alloc_dest,
  input  logic                        alloc_j_rdy,
  input  logic [DATA_W-1:0]           alloc_vj,
  input  logic [TAG_W-1:0]            alloc_qj,
  input  logic                        alloc_k_rdy,
  input  logic [DATA_W-1:0]           alloc_vk,
  input  logic [TAG_W-1:0]            alloc_qk,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_op,
  output logic [DATA_W-1:0]           issue_vj,
  output logic [DATA_W-1:0]           issue_vk,
  output logic [TAG_W-1:0]            issue_dest,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
`ifdef RS_AGE_ORDER_EN
  localparam int AGE_W = $clog2(DEPTH);
`endif

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic              j_rdy;
    logic [DATA_W-1:0] j_val;
    logic [TAG_W-1:0]  j_tag;
    logic              k_rdy;
    logic [DATA_W-1:0] k_val;
    logic [TAG_W-1:0]  k_tag;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] val;
  } snoop_t;

  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];
`ifdef RS_AGE_ORDER_EN
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];
  logic [AGE_W-1:0] best_age;
`endif

  // The selected entry is pinned while the FU stalls so issue_* cannot change
  // under a pending handshake when a lower-index or older entry wakes up.
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [DEPTH-1:0] rdy_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             do_alloc;
  logic             do_issue;
  entry_t           new_entry;
  snoop_t           snp;

  // Lowest CDB channel carrying the tag wins (scan high to low, last hit kept).
  function automatic snoop_t snoop(input logic [TAG_W-1:0]          tag,
                                   input logic [NUM_CDB-1:0]        vld,
                                   input logic [NUM_CDB*TAG_W-1:0]  tags,
                                   input logic [NUM_CDB*DATA_W-1:0] vals);
    snoop_t s;
    s = '0;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
        s.hit = 1'b1;
        s.val = vals[c*DATA_W +: DATA_W];
      end
    end
    return s;
  endfunction

  // Occupancy, ready vector, free-slot pick and issue selection from registered state.
  always_comb begin
    occupancy = '0;
    rdy_vec   = '0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy  = occupancy + OCC_W'(entry_q[i].busy);
      rdy_vec[i] = entry_q[i].busy & entry_q[i].j_rdy & entry_q[i].k_rdy;
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!entry_q[i].busy) free_idx = IDX_W'(i);
    end
    sel_idx   = '0;
    sel_found = 1'b0;
`ifdef RS_AGE_ORDER_EN
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_vec[i] && (!sel_found || (age_q[i] > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
`else
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (rdy_vec[i]) sel_idx = IDX_W'(i);
    end
    sel_found = |rdy_vec;
`endif
    if (lock_q) begin
      sel_idx   = lock_idx_q;
      sel_found = rdy_vec[lock_idx_q];
    end
  end

  // Handshake and issue outputs; data is forced to zero when nothing is selected.
  always_comb begin
    alloc_ready = (occupancy != OCC_W'(DEPTH));
    issue_valid = sel_found;
    issue_op    = sel_found ? entry_q[sel_idx].op    : '0;
    issue_vj    = sel_found ? entry_q[sel_idx].j_val : '0;
    issue_vk    = sel_found ? entry_q[sel_idx].k_val : '0;
    issue_dest  = sel_found ? entry_q[sel_idx].dest  : '0;
    do_alloc    = alloc_valid & alloc_ready & ~flush;
    do_issue    = sel_found & issue_ready & ~flush;
  end

  // Next entry state: wakeup, issue clear, allocation with same-cycle bypass, flush.
  always_comb begin
    entry_d = entry_q;
`ifdef RS_AGE_ORDER_EN
    age_d = age_q;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_q[i].busy && !entry_q[i].j_rdy) begin
        snp = snoop(entry_q[i].j_tag, cdb_valid, cdb_tag, cdb_value);
        if (snp.hit) begin
          entry_d[i].j_rdy = 1'b1;
          entry_d[i].j_val = snp.val;
        end
      end
      if (entry_q[i].busy && !entry_q[i].k_rdy) begin
        snp = snoop(entry_q[i].k_tag, cdb_valid, cdb_tag, cdb_value);
        if (snp.hit) begin
          entry_d[i].k_rdy = 1'b1;
          entry_d[i].k_val = snp.val;
        end
      end
    end

    if (do_issue) entry_d[sel_idx] = '0;

    new_entry       = '0;
    new_entry.busy  = 1'b1;
    new_entry.op    = alloc_op;
    new_entry.dest  = alloc_dest;
    new_entry.j_rdy = alloc_j_rdy;
    new_entry.j_val = alloc_j_rdy ? alloc_vj : '0;
    new_entry.j_tag = alloc_qj;
    new_entry.k_rdy = alloc_k_rdy;
    new_entry.k_val = alloc_k_rdy ? alloc_vk : '0;
    new_entry.k_tag = alloc_qk;
    snp = snoop(alloc_qj, cdb_valid, cdb_tag, cdb_value);
    if (!alloc_j_rdy && snp.hit) begin
      new_entry.j_rdy = 1'b1;
      new_entry.j_val = snp.val;
    end
    snp = snoop(alloc_qk, cdb_valid, cdb_tag, cdb_value);
    if (!alloc_k_rdy && snp.hit) begin
      new_entry.k_rdy = 1'b1;
      new_entry.k_val = snp.val;
    end

    if (do_alloc) begin
`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_q[i].busy && (age_q[i] != '1)) age_d[i] = age_q[i] + 1'b1;
      end
      age_d[free_idx] = '0;
`endif
      entry_d[free_idx] = new_entry;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i] = '0;
`ifdef RS_AGE_ORDER_EN
        age_d[i] = '0;
`endif
      end
    end

    lock_d     = sel_found & ~issue_ready & ~flush;
    lock_idx_d = sel_idx;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
`ifdef RS_AGE_ORDER_EN
        age_q[i]   <= '0;
`endif
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      entry_q    <= entry_d;
`ifdef RS_AGE_ORDER_EN
      age_q      <= age_d;
`endif
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_rs_generic.sv
// Directed bench for rs_generic with an expected-issue scoreboard queue.
module tb_rs_generic;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         alloc_valid;
  logic         alloc_ready;
  logic [3:0]   alloc_op;
  logic [3:0]   alloc_dest;
  logic         alloc_j_rdy;
  logic [31:0]  alloc_vj;
  logic [3:0]   alloc_qj;
  logic         alloc_k_rdy;
  logic [31:0]  alloc_vk;
  logic [3:0]   alloc_qk;
  logic [3:0]   cdb_valid;
  logic [15:0]  cdb_tag;
  logic [127:0] cdb_value;
  logic         issue_valid;
  logic         issue_ready;
  logic [3:0]   issue_op;
  logic [31:0]  issue_vj;
  logic [31:0]  issue_vk;
  logic [3:0]   issue_dest;
  logic [2:0]   occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  dest;
    logic [31:0] vj;
    logic [31:0] vk;
  } exp_t;

  exp_t sb[$];

  rs_generic dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_dest(alloc_dest),
    .alloc_j_rdy(alloc_j_rdy), .alloc_vj(alloc_vj), .alloc_qj(alloc_qj),
    .alloc_k_rdy(alloc_k_rdy), .alloc_vk(alloc_vk), .alloc_qk(alloc_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_dest(issue_dest), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    alloc_op    = '0;
    alloc_dest  = '0;
    alloc_j_rdy = 1'b0;
    alloc_vj    = '0;
    alloc_qj    = '0;
    alloc_k_rdy = 1'b0;
    alloc_vk    = '0;
    alloc_qk    = '0;
    cdb_valid   = '0;
    cdb_tag     = '0;
    cdb_value   = '0;
    issue_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_alloc(input logic [3:0] op, input logic [3:0] dest,
                           input logic jr, input logic [31:0] vj, input logic [3:0] qj,
                           input logic kr, input logic [31:0] vk, input logic [3:0] qk);
    alloc_valid = 1'b1;
    alloc_op    = op;
    alloc_dest  = dest;
    alloc_j_rdy = jr;
    alloc_vj    = vj;
    alloc_qj    = qj;
    alloc_k_rdy = kr;
    alloc_vk    = vk;
    alloc_qk    = qk;
  endtask

  task automatic cdb_set(input int ch, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[ch]          = 1'b1;
    cdb_tag[ch*4 +: 4]     = tag;
    cdb_value[ch*32 +: 32] = val;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] dest,
                      input logic [31:0] vj, input logic [31:0] vk);
    exp_t e;
    e.op = op; e.dest = dest; e.vj = vj; e.vk = vk;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_valid"}, issue_valid, 1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_op"},   issue_op,   e.op);
      chk({tag, "_dest"}, issue_dest, e.dest);
      chk({tag, "_vj"},   issue_vj,   e.vj);
      chk({tag, "_vk"},   issue_vk,   e.vk);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk("rst_occ",   occupancy,   0);
    chk("rst_ar",    alloc_ready, 1);
    chk("rst_iv",    issue_valid, 0);
    chk("rst_vj",    issue_vj,    0);
    chk("rst_dest",  issue_dest,  0);
    tick();
    rst = 1'b0;

    // basic ready-at-alloc instruction
    tick();
    set_alloc(3, 5, 1, 10, 0, 1, 20, 0);
    push(3, 5, 10, 20);
    settle();
    chk("t1_pre_iv", issue_valid, 0);
    tick(); idle(); settle();
    chk("t1_occ", occupancy, 1);
    pop_check("t1");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    chk("t1_occ_after", occupancy, 0);
    chk("t1_iv_after", issue_valid, 0);

    // wakeup through CDB, lowest matching channel wins
    set_alloc(1, 2, 0, 0, 7, 1, 5, 0);
    tick(); idle(); settle();
    chk("t2_wait0", issue_valid, 0);
    tick(); settle();
    chk("t2_wait1", issue_valid, 0);
    tick();
    cdb_set(2, 7, 32'hDEAD);
    cdb_set(3, 7, 32'hBEEF);
    push(1, 2, 32'hDEAD, 5);
    settle();
    chk("t2_no_comb", issue_valid, 0);
    tick(); idle(); settle();
    pop_check("t2");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    chk("t2_occ", occupancy, 0);

    // allocation-cycle bypass
    set_alloc(2, 9, 0, 0, 9, 1, 1, 0);
    cdb_set(0, 9, 42);
    push(2, 9, 42, 1);
    tick(); idle(); settle();
    pop_check("t3");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    chk("t3_occ", occupancy, 0);

    // fill to DEPTH, ignored alloc when full, slot reuse one cycle late
    for (int i = 0; i < 4; i++) begin
      set_alloc(4'(4 + i), 4'(8 + i), 0, 0, 4'(i), 1, 32'(100 + i), 0);
      tick();
    end
    idle(); settle();
    chk("t4_ar_full", alloc_ready, 0);
    chk("t4_occ_full", occupancy, 4);
    chk("t4_iv_none", issue_valid, 0);
    set_alloc(15, 15, 1, 1, 0, 1, 1, 0);
    tick(); idle(); settle();
    chk("t4_ignored_occ", occupancy, 4);
    chk("t4_ignored_iv", issue_valid, 0);
    cdb_set(1, 2, 77);
    push(6, 10, 77, 102);
    tick(); idle(); settle();
    pop_check("t4_wake");
    issue_ready = 1'b1;
    set_alloc(13, 13, 1, 3, 0, 1, 4, 0);
    settle();
    chk("t4_ar_same_cycle", alloc_ready, 0);
    tick(); idle(); settle();
    chk("t4_occ3", occupancy, 3);
    chk("t4_ar_next", alloc_ready, 1);
    chk("t4_iv_after", issue_valid, 0);
    set_alloc(12, 14, 1, 55, 0, 1, 66, 0);
    push(12, 14, 55, 66);
    tick(); idle(); settle();
    chk("t4_occ4", occupancy, 4);
    pop_check("t4_x");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    chk("t4_occ_end", occupancy, 3);

    // flush with a concurrent allocation
    flush = 1'b1;
    set_alloc(7, 7, 1, 1, 0, 1, 2, 0);
    tick(); idle(); settle();
    chk("t5_occ", occupancy, 0);
    chk("t5_iv", issue_valid, 0);
    chk("t5_ar", alloc_ready, 1);
    cdb_set(0, 0, 1);
    cdb_set(1, 1, 1);
    cdb_set(2, 3, 1);
    tick(); idle(); settle();
    chk("t5_no_ghost", issue_valid, 0);
    chk("t5_occ_still", occupancy, 0);

    // issue order: older entry in slot1 vs younger entry in slot0
    set_alloc(1, 1, 1, 11, 0, 1, 12, 0);
    push(1, 1, 11, 12);
    tick();
    set_alloc(2, 2, 0, 0, 12, 1, 22, 0);
    tick(); idle(); settle();
    pop_check("t6_p");
    issue_ready = 1'b1;
    tick(); idle();
    set_alloc(3, 3, 0, 0, 13, 1, 33, 0);
    tick(); idle();
    cdb_set(0, 12, 32'h120);
    cdb_set(1, 13, 32'h130);
`ifdef RS_AGE_ORDER_EN
    push(2, 2, 32'h120, 22);
    push(3, 3, 32'h130, 33);
`else
    push(3, 3, 32'h130, 33);
    push(2, 2, 32'h120, 22);
`endif
    tick(); idle(); settle();
    chk("t6_occ", occupancy, 2);
    pop_check("t6_first");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    pop_check("t6_second");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    chk("t6_occ_end", occupancy, 0);

    // stall stability and simultaneous alloc + issue
    set_alloc(4, 4, 0, 0, 14, 1, 44, 0);
    tick();
    set_alloc(5, 5, 1, 50, 0, 1, 55, 0);
    push(5, 5, 50, 55);
    tick(); idle(); settle();
    chk("t7_sel", issue_dest, 5);
    cdb_set(0, 14, 32'h140);
    push(4, 4, 32'h140, 44);
    tick(); idle(); settle();
    chk("t7_stable_dest", issue_dest, 5);
    chk("t7_stable_vj", issue_vj, 50);
    chk("t7_occ", occupancy, 2);
    pop_check("t7_b");
    issue_ready = 1'b1;
    set_alloc(6, 6, 1, 60, 0, 1, 66, 0);
    push(6, 6, 60, 66);
    tick(); idle(); settle();
    chk("t7_occ_same", occupancy, 2);
    pop_check("t7_f");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    pop_check("t7_g");
    issue_ready = 1'b1;
    tick(); idle(); settle();
    chk("t7_occ_end", occupancy, 0);
    chk("t7_sb_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
